elevator_call_panel: RTL

// Request side of the 4-floor elevator car interface. Debounces raw call buttons,

---
 rtl/elevator_call_panel_if.sv | 26 ++
 rtl/elevator_call_panel.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/elevator_call_panel_if.sv
// Call-panel <-> car bundle.
//   btn_raw      : raw call buttons, bit i = floor i (from the hall/car panel)
//   floor        : current floor, one-hot (from the floor controller)
//   button       : target floor, one-hot (to the floor controller)
//   call_pending : latched calls / call lamps
//   dir_up       : current sweep direction, 1 = up
//   floor_err    : sticky flag, floor was seen not one-hot
// master = the call panel, slave = the controller/panel hardware around it.
interface elevator_call_panel_if;
  logic [3:0] btn_raw;
  logic [3:0] floor;
  logic [3:0] button;
  logic [3:0] call_pending;
  logic       dir_up;
  logic       floor_err;

  modport master (
    input  btn_raw, floor,
    output button, call_pending, dir_up, floor_err
  );

  modport slave (
    output btn_raw, floor,
    input  button, call_pending, dir_up, floor_err
  );
endinterface

// File: rtl/elevator_call_panel.sv
// Request side of a 4-floor elevator car. Debounces the raw call buttons,
// latches calls, and serves them in SCAN order by driving a one-hot target
// floor into the floor controller; holds the car for a door dwell at each
// served floor.
// Ports:
//   clk  : system clock, everything on posedge
//   rst  : synchronous reset, active-high
//   bus  : elevator_call_panel_if.master (btn_raw/floor in; button,
//          call_pending, dir_up, floor_err out, all outputs registered)
module elevator_call_panel #(
  parameter int DEB_CYCLES   = 16,
  parameter int DWELL_CYCLES = 8,
  parameter int CNT_W        = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  elevator_call_panel_if.master  bus
);

  typedef enum logic [1:0] {IDLE, UP, DOWN, DWELL} state_e;

  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);

  state_e           state_q, state_d;
  logic [3:0]       pending_q, pending_d;
  logic [3:0]       button_q, button_d;
  logic             dir_up_q, dir_up_d;
  logic             floor_err_q;
  logic [1:0]       cur_q, cur_c;
  logic [CNT_W-1:0] dwell_q, dwell_d;

  logic [CNT_W-1:0] deb_cnt_q [4];
  logic [3:0]       deb_lvl_q;
  logic [3:0]       deb_prev_q;

  logic             floor_ok;
  logic [3:0]       rise;
  logic [3:0]       cur_oh;
  logic [3:0]       above;
  logic [3:0]       below;
  logic [3:0]       clr_mask;
  logic [3:0]       absorb_mask;

  function automatic logic [1:0] encode(input logic [3:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++)
      if (oh[i]) idx = 2'(i);
    return idx;
  endfunction

  function automatic logic [3:0] mask_above(input logic [1:0] idx);
    logic [3:0] m;
    m = '0;
    for (int i = 0; i < 4; i++)
      if (i > int'(idx)) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [3:0] mask_below(input logic [1:0] idx);
    logic [3:0] m;
    m = '0;
    for (int i = 0; i < 4; i++)
      if (i < int'(idx)) m[i] = 1'b1;
    return m;
  endfunction

  // Scanning downward so the last hit is the lowest set bit.
  function automatic logic [3:0] lowest_oh(input logic [3:0] m);
    logic [3:0] r;
    r = '0;
    for (int i = 3; i >= 0; i--)
      if (m[i]) r = 4'b0001 << i;
    return r;
  endfunction

  function automatic logic [3:0] highest_oh(input logic [3:0] m);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 4; i++)
      if (m[i]) r = 4'b0001 << i;
    return r;
  endfunction

  // Debounce: the counter runs only while the raw level disagrees with the
  // accepted level; any agreeing sample restarts it, so a bounce never
  // accumulates toward a flip.
  for (genvar g = 0; g < 4; g++) begin : g_deb
    always_ff @(posedge clk) begin
      if (rst) begin
        deb_cnt_q[g]  <= '0;
        deb_lvl_q[g]  <= 1'b0;
        deb_prev_q[g] <= 1'b0;
      end else begin
        deb_prev_q[g] <= deb_lvl_q[g];
        if (bus.btn_raw[g] == deb_lvl_q[g]) begin
          deb_cnt_q[g] <= '0;
        end else if (deb_cnt_q[g] == DEB_LAST) begin
          deb_cnt_q[g] <= '0;
          deb_lvl_q[g] <= bus.btn_raw[g];
        end else begin
          deb_cnt_q[g] <= deb_cnt_q[g] + 1'b1;
        end
      end
    end
  end

  assign rise     = deb_lvl_q & ~deb_prev_q;
  assign floor_ok = $onehot(bus.floor);
  // A corrupt floor reading falls back to the last good position.
  assign cur_c    = floor_ok ? encode(bus.floor) : cur_q;
  assign cur_oh   = 4'b0001 << cur_c;
  assign above    = pending_q & mask_above(cur_c);
  assign below    = pending_q & mask_below(cur_c);

  always_comb begin
    state_d     = state_q;
    dir_up_d    = dir_up_q;
    button_d    = button_q;
    dwell_d     = dwell_q;
    clr_mask    = '0;
    absorb_mask = '0;

    // With an invalid floor everything except call latching is frozen.
    if (floor_ok) begin
      unique case (state_q)
        IDLE: begin
          if (pending_q[cur_c]) state_d = DWELL;
          else if (|above)      state_d = UP;
          else if (|below)      state_d = DOWN;
          else                  state_d = IDLE;
        end
        UP: begin
          if (pending_q[cur_c]) state_d = DWELL;
          else if (|above)      state_d = UP;
          else if (|below)      state_d = DOWN;
          else                  state_d = IDLE;
        end
        DOWN: begin
          if (pending_q[cur_c]) state_d = DWELL;
          else if (|below)      state_d = DOWN;
          else if (|above)      state_d = UP;
          else                  state_d = IDLE;
        end
        DWELL: begin
          if (rise[cur_c]) begin
            // Someone pressed this floor's button while the doors are open:
            // treat it as "hold the door", not as a new call.
            absorb_mask = cur_oh;
            dwell_d     = DWELL_LOAD;
          end else if (dwell_q != '0) begin
            dwell_d = dwell_q - 1'b1;
          end else if (dir_up_q) begin
            if (|above)      state_d = UP;
            else if (|below) state_d = DOWN;
            else             state_d = IDLE;
          end else begin
            if (|below)      state_d = DOWN;
            else if (|above) state_d = UP;
            else             state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase

      // The target is chosen from the state being entered, so a call is
      // reflected on `button` one cycle after it latches.
      unique case (state_d)
        UP: begin
          dir_up_d = 1'b1;
          button_d = lowest_oh(above);
        end
        DOWN: begin
          dir_up_d = 1'b0;
          button_d = highest_oh(below);
        end
        default: button_d = cur_oh;
      endcase

      if (state_d == DWELL && state_q != DWELL) begin
        clr_mask = cur_oh;
        dwell_d  = DWELL_LOAD;
      end
    end
  end

  // A new press wins over a same-cycle clear.
  assign pending_d = (pending_q & ~clr_mask) | (rise & ~absorb_mask);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      button_q    <= 4'b0001;
      dir_up_q    <= 1'b1;
      floor_err_q <= 1'b0;
      cur_q       <= 2'd0;
      dwell_q     <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      button_q    <= button_d;
      dir_up_q    <= dir_up_d;
      floor_err_q <= floor_err_q | ~floor_ok;
      cur_q       <= cur_c;
      dwell_q     <= dwell_d;
    end
  end

  assign bus.button       = button_q;
  assign bus.call_pending = pending_q;
  assign bus.dir_up       = dir_up_q;
  assign bus.floor_err    = floor_err_q;

endmodule
